// File: rtl/up_sampler_pkg.sv
// Shared helpers for the AXI4-Stream rate-change blocks (up_sampler, down_sampler).
package up_sampler_pkg;

   // Phase counter width; a factor of 1 still needs a 1-bit register.
   function automatic int cnt_w(input int factor);
      return (factor > 1) ? $clog2(factor) : 1;
   endfunction

endpackage

// File: rtl/up_sampler.sv
// AXI4-Stream interpolator: each accepted sample is emitted as U_FACTOR beats.
// Build option UP_SAMPLER_ZERO_STUFF_EN: sample then zeros instead of zero-order hold.
module up_sampler
   import up_sampler_pkg::*;
#(
   parameter int U_FACTOR    = 4,
   parameter int TDATA_WIDTH = 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tlast
);

   localparam int               CNT_W      = cnt_w(U_FACTOR);
   localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(U_FACTOR - 1);

   logic [TDATA_WIDTH-1:0] data_q;
   logic [CNT_W-1:0]       phase_q;
   logic                   valid_q;
   logic                   last;
   logic                   fire_m;
   logic                   fire_s;

   assign last   = (phase_q == LAST_PHASE);
   assign fire_m = valid_q && m_axis_tready;

   // Ready opens on the final beat so the next burst starts without a bubble.
   assign s_axis_tready = aresetn && (!valid_q || (m_axis_tready && last));
   assign fire_s        = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_q  <= '0;
         phase_q <= '0;
         valid_q <= 1'b0;
      end else if (fire_s) begin
         // NOTE: non-blocking assignments keep every register updating from
         // the pre-edge values, regardless of statement order.
         data_q  <= s_axis_tdata;
         phase_q <= '0;
         valid_q <= 1'b1;
      end else if (fire_m) begin
         if (last) begin
            valid_q <= 1'b0;
            phase_q <= '0;
         end else begin
            phase_q <= phase_q + 1'b1;
         end
      end
   end

   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = valid_q && last;

`ifdef UP_SAMPLER_ZERO_STUFF_EN
   assign m_axis_tdata = (phase_q == '0) ? data_q : '0;
`else
   assign m_axis_tdata = data_q;
`endif

endmodule

// File: tb/tb_up_sampler.sv
// Directed and randomized-handshake bench for up_sampler (U=4 and U=1 instances).
module tb_up_sampler;

   logic       aclk = 1'b0;
   logic       aresetn;
   always #5 aclk = ~aclk;

   logic       s_valid, s_ready, m_valid, m_ready, m_last;
   logic [7:0] s_data, m_data;
   logic       s_valid1, s_ready1, m_valid1, m_ready1, m_last1;
   logic [7:0] s_data1, m_data1;

   up_sampler #(.U_FACTOR(4), .TDATA_WIDTH(8)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
      .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
      .m_axis_tlast(m_last)
   );

   up_sampler #(.U_FACTOR(1), .TDATA_WIDTH(8)) dut1 (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s_valid1), .s_axis_tready(s_ready1), .s_axis_tdata(s_data1),
      .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready1), .m_axis_tdata(m_data1),
      .m_axis_tlast(m_last1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected output data for a held sample at a given burst phase.
   function automatic logic [7:0] ed(input logic [7:0] s, input int ph);
`ifdef UP_SAMPLER_ZERO_STUFF_EN
      return (ph == 0) ? s : 8'h00;
`else
      return s;
`endif
   endfunction

   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       mr;
      logic       ev;
      logic [7:0] edat;
      logic       el;
      logic       er;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic sv, input logic [7:0] sd, input logic mr,
                      input logic ev, input logic [7:0] edat, input logic el, input logic er);
      vec_t v;
      v.sv = sv; v.sd = sd; v.mr = mr;
      v.ev = ev; v.edat = edat; v.el = el; v.er = er;
      vt.push_back(v);
   endtask

   // Idle -> accept a, hold b on the input during a's burst, accept b on a's tlast.
   task automatic add_pair(input logic [7:0] prev, input logic [7:0] a, input logic [7:0] b);
      add(1, a, 1, 0, prev, 0, 1);
      for (int p = 0; p < 4; p++) add(1, b, 1, 1, ed(a, p), p == 3, p == 3);
      for (int p = 0; p < 4; p++) add(0, 8'h00, 1, 1, ed(b, p), p == 3, p == 3);
   endtask

   logic [7:0] exp_q[$];
   logic [7:0] exp_s;
   int         sent, recvd, cyc;
   logic       s_fire_prev, s_fire, m_fire;

   initial begin
      aresetn = 1'b0;
      s_valid = 0; s_data = 0; m_ready = 0;
      s_valid1 = 0; s_data1 = 0; m_ready1 = 0;
      #12;
      check("rst m_valid", 32'(m_valid), 32'(0));
      check("rst m_last",  32'(m_last),  32'(0));
      check("rst m_data",  32'(m_data),  32'(0));
      check("rst s_ready", 32'(s_ready), 32'(0));
      @(negedge aclk);
      aresetn = 1'b1;

      // Single burst of 0x11
      add(1, 8'h11, 1, 0, 8'h00, 0, 1);
      for (int p = 0; p < 4; p++) add(0, 8'h00, 1, 1, ed(8'h11, p), p == 3, p == 3);
      add(0, 8'h00, 1, 0, 8'h11, 0, 1);
      // Back-to-back bursts, zero bubble
      add_pair(8'h11, 8'h01, 8'h02);
      add(0, 8'h00, 1, 0, 8'h02, 0, 1);
      add_pair(8'h02, 8'h7F, 8'h80);
      add(0, 8'h00, 1, 0, 8'h80, 0, 1);
      // Three-cycle downstream stall on beat 2 of 0xA5
      add(1, 8'hA5, 1, 0, 8'h80, 0, 1);
      add(0, 8'h00, 1, 1, ed(8'hA5, 0), 0, 0);
      for (int k = 0; k < 3; k++) add(0, 8'h00, 0, 1, ed(8'hA5, 1), 0, 0);
      for (int p = 1; p < 4; p++) add(0, 8'h00, 1, 1, ed(8'hA5, p), p == 3, p == 3);
      add(0, 8'h00, 1, 0, 8'hA5, 0, 1);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge aclk);
         s_valid = vt[i].sv; s_data = vt[i].sd; m_ready = vt[i].mr;
         #1;
         check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vt[i].ev));
         check($sformatf("vec%0d m_data", i),  32'(m_data),  32'(vt[i].edat));
         check($sformatf("vec%0d m_last", i),  32'(m_last),  32'(vt[i].el));
         check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vt[i].er));
      end

      // Asynchronous reset during beat 2 of 0x3C
      @(negedge aclk);
      s_valid = 1; s_data = 8'h3C; m_ready = 1;
      @(negedge aclk);
      s_valid = 0;
      #1 check("mid p0 data", 32'(m_data), 32'(ed(8'h3C, 0)));
      @(negedge aclk);
      #1 check("mid p1 valid", 32'(m_valid), 32'(1));
      aresetn = 1'b0;
      #1;
      check("mid rst m_valid", 32'(m_valid), 32'(0));
      check("mid rst m_last",  32'(m_last),  32'(0));
      check("mid rst m_data",  32'(m_data),  32'(0));
      check("mid rst s_ready", 32'(s_ready), 32'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check("post rst m_valid", 32'(m_valid), 32'(0));
      check("post rst s_ready", 32'(s_ready), 32'(1));
      s_valid = 1; s_data = 8'h5A;
      for (int p = 0; p < 4; p++) begin
         @(negedge aclk);
         s_valid = 0;
         #1;
         check($sformatf("post p%0d valid", p), 32'(m_valid), 32'(1));
         check($sformatf("post p%0d data", p),  32'(m_data),  32'(ed(8'h5A, p)));
         check($sformatf("post p%0d last", p),  32'(m_last),  32'(p == 3));
      end
      @(negedge aclk);
      #1 check("post idle valid", 32'(m_valid), 32'(0));

      // U=1 register slice under random handshakes
      sent = 0; recvd = 0; cyc = 0; s_fire_prev = 0;
      while (recvd < 1000 && cyc < 20000) begin
         @(negedge aclk);
         cyc++;
         if (s_fire_prev) s_valid1 = 0;
         if (!s_valid1 && sent < 1000 && $urandom_range(0, 3) != 0) begin
            s_valid1 = 1;
            s_data1  = 8'($urandom);
         end
         m_ready1 = ($urandom_range(0, 3) != 0);
         #1;
         check("u1 s_ready", 32'(s_ready1), 32'(!m_valid1 || m_ready1));
         if (m_valid1) check("u1 m_last", 32'(m_last1), 32'(1));
         s_fire = s_valid1 && s_ready1;
         m_fire = m_valid1 && m_ready1;
         if (m_fire) begin
            if (exp_q.size() == 0) begin
               failures++;
               checks++;
               $display("FAIL u1 extra beat: got %0h expected none", m_data1);
            end else begin
               exp_s = exp_q.pop_front();
               check($sformatf("u1 data%0d", recvd), 32'(m_data1), 32'(exp_s));
            end
            recvd++;
         end
         if (s_fire) begin
            exp_q.push_back(s_data1);
            sent++;
         end
         s_fire_prev = s_fire;
      end
      check("u1 received", 32'(recvd), 32'(1000));
      check("u1 leftover", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
